// File: rtl/ser_frame_rx.sv
// Serial frame receiver (start, DATA_W bits LSB first, [even parity if SER_FRAME_RX_PARITY_EN], stop);
// data_valid/frame_err fire 2 + (bits-1)*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the start edge, no backpressure.
module ser_frame_rx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 8,
   parameter int NOM_W        = 4
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              rx,
   output logic [DATA_W-1:0] EL,
   output logic [NOM_W-1:0]  NOM,
   output logic [1:0]        BIT,
   output logic              busy,
   output logic              data_valid,
   output logic              frame_err
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_sync;
   logic [TW-1:0]     r_tcnt, w_tcnt_nxt;
   logic [2:0]        r_bitcnt, w_bitcnt_nxt;
   logic [DATA_W-1:0] r_shift, w_shift_nxt;
   logic [DATA_W-1:0] r_el, w_el_nxt;
   logic [NOM_W-1:0]  r_nom, w_nom_nxt;
   logic              r_dv, w_dv_nxt;
   logic              r_ferr, w_ferr_nxt;
   logic              w_rx_s;
`ifdef SER_FRAME_RX_PARITY_EN
   logic              r_par_err, w_par_err_nxt;
`endif

   assign w_rx_s = r_sync[1];

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_sync   <= 2'b11;
         r_tcnt   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_el     <= '0;
         r_nom    <= '0;
         r_dv     <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sync   <= {r_sync[0], rx};
         r_tcnt   <= w_tcnt_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_shift  <= w_shift_nxt;
         r_el     <= w_el_nxt;
         r_nom    <= w_nom_nxt;
         r_dv     <= w_dv_nxt;
         r_ferr   <= w_ferr_nxt;
      end
   end

`ifdef SER_FRAME_RX_PARITY_EN
   always_ff @(posedge clk or posedge RST) begin
      if (RST) r_par_err <= 1'b0;
      else     r_par_err <= w_par_err_nxt;
   end
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_tcnt_nxt   = (r_tcnt == FULL_M1) ? '0 : r_tcnt + 1'b1;
      w_bitcnt_nxt = r_bitcnt;
      w_shift_nxt  = r_shift;
      w_el_nxt     = r_el;
      w_nom_nxt    = r_nom;
      w_dv_nxt     = 1'b0;
      w_ferr_nxt   = 1'b0;
`ifdef SER_FRAME_RX_PARITY_EN
      w_par_err_nxt = r_par_err;
`endif
      case (r_state)
         S_IDLE: begin
            w_tcnt_nxt = '0;
            if (!w_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            // Mid-bit recheck rejects short glitches on the idle line.
            if (r_tcnt == HALF_M1) begin
               w_tcnt_nxt   = '0;
               w_bitcnt_nxt = '0;
               w_state_nxt  = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_tcnt == FULL_M1) begin
               w_shift_nxt             = r_shift >> 1;
               w_shift_nxt[DATA_W-1]   = w_rx_s;
               if (r_bitcnt == LAST_BIT) begin
                  w_bitcnt_nxt = '0;
`ifdef SER_FRAME_RX_PARITY_EN
                  w_state_nxt  = S_PARITY;
`else
                  w_state_nxt  = S_STOP;
`endif
               end else begin
                  w_bitcnt_nxt = r_bitcnt + 1'b1;
               end
            end
         end
`ifdef SER_FRAME_RX_PARITY_EN
         S_PARITY: begin
            if (r_tcnt == FULL_M1) begin
               w_par_err_nxt = (^r_shift) ^ w_rx_s;
               w_state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_tcnt == FULL_M1) begin
               if (w_rx_s) begin
                  w_state_nxt = S_IDLE;
`ifdef SER_FRAME_RX_PARITY_EN
                  if (r_par_err) begin
                     w_ferr_nxt = 1'b1;
                  end else begin
                     w_el_nxt  = r_shift;
                     w_nom_nxt = r_nom + 1'b1;
                     w_dv_nxt  = 1'b1;
                  end
`else
                  w_el_nxt  = r_shift;
                  w_nom_nxt = r_nom + 1'b1;
                  w_dv_nxt  = 1'b1;
`endif
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // A held-low line must return high before another start is accepted.
            w_tcnt_nxt = '0;
            if (w_rx_s) w_state_nxt = S_IDLE;
         end
         default: begin
            w_tcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign EL         = r_el;
   assign NOM        = r_nom;
   assign BIT        = (r_state == S_DATA) ? r_bitcnt[1:0] : 2'd0;
   assign busy       = (r_state != S_IDLE);
   assign data_valid = r_dv;
   assign frame_err  = r_ferr;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Directed bench for ser_frame_rx: frame-level event model plus literal spot checks.
module tb_ser_frame_rx;

   localparam int DATA_W = 4;
   localparam int CPB    = 8;
   localparam int NOM_W  = 4;
`ifdef SER_FRAME_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB  = DATA_W + 2 + PAR;
   localparam int LAT = 2 + (NB - 1) * CPB + CPB / 2;

   logic              clk = 1'b0;
   logic              RST = 1'b1;
   logic              rx  = 1'b1;
   logic [DATA_W-1:0] EL;
   logic [NOM_W-1:0]  NOM;
   logic [1:0]        BIT;
   logic              busy, data_valid, frame_err;

   ser_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .NOM_W(NOM_W)) dut (
      .clk(clk), .RST(RST), .rx(rx), .EL(EL), .NOM(NOM), .BIT(BIT),
      .busy(busy), .data_valid(data_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      bit         good;
      logic [3:0] d;
   } ev_t;

   ev_t        q[$];
   logic [3:0] exp_el  = '0;
   logic [3:0] exp_nom = '0;
   int         n_checks = 0;
   int         n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Frame-level model: each sent frame yields one strobe LAT cycles after its start edge.
   always @(negedge clk) begin
      logic exp_dv, exp_fe;
      exp_dv = 1'b0;
      exp_fe = 1'b0;
      if (!RST) begin
         while (q.size() > 0 && q[0].t < cyc) begin
            check("evt_time", q[0].t, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].t == cyc) begin
            if (q[0].good) begin
               exp_dv  = 1'b1;
               exp_el  = q[0].d;
               exp_nom = exp_nom + 4'd1;
            end else begin
               exp_fe = 1'b1;
            end
            void'(q.pop_front());
         end
      end
      check("model_dv", data_valid, exp_dv);
      check("model_ferr", frame_err, exp_fe);
      check("model_el", EL, exp_el);
      check("model_nom", NOM, exp_nom);
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Call only right after a falling clock edge.
   task automatic send_frame(input logic [3:0] d, input bit stop, input bit par_bad);
      ev_t e;
      e.t    = cyc + 1 + LAT;
      e.good = stop && !(PAR == 1 && par_bad);
      e.d    = d;
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
      if (PAR == 1) drive_bit((^d) ^ par_bad);
      drive_bit(stop);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      int f;
      logic [3:0] seq3 [3];
      seq3[0] = 4'h3; seq3[1] = 4'hF; seq3[2] = 4'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_el", EL, 0);
      check("rst_nom", NOM, 0);
      check("rst_bit", BIT, 0);
      check("rst_busy", busy, 0);
      #2 RST = 1'b0;
      repeat (200) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_nom", NOM, 0);

      // Single frame 4'hA: latency, BIT stepping
      f = cyc + 1;
      fork
         send_frame(4'hA, 1'b1, 1'b0);
         begin
            wait_until(f + 3);
            check("a_busy", busy, 1);
            for (int k = 0; k < 4; k++) begin
               wait_until(f + 12 + 8 * k);
               check("a_bit_idx", BIT, k);
            end
            wait_until(f + LAT - 1);
            check("a_dv_early", data_valid, 0);
            wait_until(f + LAT);
            check("a_dv", data_valid, 1);
            check("a_el", EL, 4'hA);
            check("a_nom", NOM, 1);
            wait_until(f + LAT + 1);
            check("a_dv_late", data_valid, 0);
            check("a_busy_done", busy, 0);
         end
      join

      // Back-to-back frames, then wrap NOM
      for (int i = 0; i < 3; i++) send_frame(seq3[i], 1'b1, 1'b0);
      check("b2b_el", EL, 4'h0);
      check("b2b_nom", NOM, 4);
      for (int i = 0; i < 12; i++) send_frame(4'(i), 1'b1, 1'b0);
      check("wrap_nom", NOM, 0);
      check("wrap_el", EL, 4'hB);
      repeat (20) @(negedge clk);

      // Short glitch is rejected
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_busy", busy, 0);
      check("glitch_nom", NOM, 0);

      // Stop-bit error and held-low line
      send_frame(4'h5, 1'b0, 1'b0);
      check("serr_el", EL, 4'hB);
      check("serr_nom", NOM, 0);
      repeat (50) @(negedge clk);
      check("break_busy", busy, 1);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      check("break_exit", busy, 0);
      send_frame(4'h9, 1'b1, 1'b0);
      check("after_break_el", EL, 4'h9);
      check("after_break_nom", NOM, 1);
      repeat (10) @(negedge clk);

      // Reset in the middle of frame 4'hC
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", busy, 1);
      #2 RST = 1'b1;
      exp_el  = '0;
      exp_nom = '0;
      q.delete();
      #1;
      check("mrst_el", EL, 0);
      check("mrst_nom", NOM, 0);
      check("mrst_busy", busy, 0);
      check("mrst_dv", data_valid, 0);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      #2 RST = 1'b0;
      repeat (20) @(negedge clk);
      send_frame(4'h6, 1'b1, 1'b0);
      check("post_rst_el", EL, 4'h6);
      check("post_rst_nom", NOM, 1);
      repeat (10) @(negedge clk);

`ifdef SER_FRAME_RX_PARITY_EN
      send_frame(4'h7, 1'b1, 1'b1);
      check("par_bad_nom", NOM, 1);
      check("par_bad_el", EL, 4'h6);
      repeat (5) @(negedge clk);
      send_frame(4'h7, 1'b1, 1'b0);
      check("par_ok_el", EL, 4'h7);
      check("par_ok_nom", NOM, 2);
`endif

      repeat (20) @(negedge clk);
      check("evt_pending", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
